// File: rtl/lsu_wb.sv
// lsu_wb: load/store unit on a 32-bit big-endian Wishbone-style bus.
// One LD/ST per request; byte/half/word sizes, sign/zero extension,
// word accesses at byte offset 2 split into two halfword bus cycles.
// Optional bus watchdog: define LSU_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module lsu_wb #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic [3:0]  o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t      state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_res;
    logic        r_err;
    logic        r_gap;

    logic        req_bad;
    logic        split;
    logic        tmo_hit;
    logic        bus_end;
    logic        bus_fail;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_val;

    // Byte-lane strobes for the first (or only) bus access of a request
    function automatic logic [3:0] lane_stb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_stb = 4'b1000 >> off;
            2'b01:   lane_stb = off[1] ? 4'b0011 : 4'b1100;
            default: lane_stb = off[1] ? 4'b0011 : 4'b1111;
        endcase
    endfunction

    // Store data replicated onto the lanes of the first (or only) access
    function automatic logic [31:0] lane_dat(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] d);
        case (size)
            2'b00:   lane_dat = {4{d[7:0]}};
            2'b01:   lane_dat = {2{d[15:0]}};
            default: lane_dat = off[1] ? {2{d[31:16]}} : d;
        endcase
    endfunction

`ifdef LSU_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Watchdog: counts cycles with cyc high; cyc always drops between accesses
    always_ff @(posedge i_clk) begin
        if (i_reset || !o_wb_cyc)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 32'd1;
    end

    assign tmo_hit = o_wb_cyc && (tmo_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Request legality, access termination and load-lane extraction
    always_comb begin
        req_bad  = (i_size == 2'b11) || ((i_size != 2'b00) && i_addr[0]);
        split    = (r_size == 2'b10) && r_addr[1];
        bus_end  = o_wb_cyc && (i_wb_ack || i_wb_err || tmo_hit);
        bus_fail = i_wb_err || tmo_hit;
        case (r_addr[1:0])
            2'b00:   rd_byte = i_wb_dat[31:24];
            2'b01:   rd_byte = i_wb_dat[23:16];
            2'b10:   rd_byte = i_wb_dat[15:8];
            default: rd_byte = i_wb_dat[7:0];
        endcase
        rd_half = r_addr[1] ? i_wb_dat[15:0] : i_wb_dat[31:16];
        case (r_size)
            2'b00:   ld_val = {{24{r_signed & rd_byte[7]}}, rd_byte};
            2'b01:   ld_val = {{16{r_signed & rd_half[15]}}, rd_half};
            default: ld_val = i_wb_dat;
        endcase
    end

    // Main request FSM with registered bus and handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_data    <= '0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= '0;
            o_wb_we   <= 1'b0;
            o_wb_addr <= '0;
            o_wb_dat  <= '0;
            r_we      <= 1'b0;
            r_size    <= '0;
            r_signed  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_res     <= '0;
            r_err     <= 1'b0;
            r_gap     <= 1'b0;
        end else begin
            o_done  <= 1'b0;
            o_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        r_we     <= i_we;
                        r_size   <= i_size;
                        r_signed <= i_signed;
                        r_addr   <= i_addr;
                        r_wdata  <= i_data;
                        o_busy   <= 1'b1;
                        if (req_bad) begin
                            r_err <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Bus cycle is launched straight from the request inputs
                            r_err     <= 1'b0;
                            o_wb_cyc  <= 1'b1;
                            o_wb_addr <= {i_addr[31:2], 2'b00};
                            o_wb_stb  <= lane_stb(i_size, i_addr[1:0]);
                            o_wb_we   <= i_we;
                            o_wb_dat  <= lane_dat(i_size, i_addr[1:0], i_data);
                            state     <= ACC1;
                        end
                    end
                end
                ACC1: begin
                    if (bus_end) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= '0;
                        o_wb_we  <= 1'b0;
                        if (bus_fail) begin
                            r_err <= 1'b1;
                            state <= DONE;
                        end else if (split) begin
                            r_res[31:16] <= i_wb_dat[15:0];
                            r_gap        <= 1'b1;
                            state        <= ACC2;
                        end else begin
                            r_res <= ld_val;
                            state <= DONE;
                        end
                    end
                end
                ACC2: begin
                    // Two idle cycles with cyc low precede the second halfword access
                    if (!o_wb_cyc) begin
                        if (r_gap) begin
                            r_gap <= 1'b0;
                        end else begin
                            o_wb_cyc  <= 1'b1;
                            o_wb_addr <= {r_addr[31:2], 2'b00} + 32'd4;
                            o_wb_stb  <= 4'b1100;
                            o_wb_we   <= r_we;
                            o_wb_dat  <= {2{r_wdata[15:0]}};
                        end
                    end else if (bus_end) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= '0;
                        o_wb_we  <= 1'b0;
                        if (bus_fail)
                            r_err <= 1'b1;
                        else
                            r_res[15:0] <= i_wb_dat[31:16];
                        state <= DONE;
                    end
                end
                default: begin
                    o_done  <= 1'b1;
                    o_error <= r_err;
                    o_busy  <= 1'b0;
                    if (!r_we && !r_err)
                        o_data <= r_res;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: scoreboard bench for lsu_wb. Stimulus pushes expected bus
// accesses and request completions; a slave process and a completion
// monitor pop and compare. Reference model works on byte addresses.
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_we, i_signed;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_data;
    logic [31:0] o_data, o_wb_addr, o_wb_dat, i_wb_dat;
    logic        o_busy, o_done, o_error, o_wb_cyc, o_wb_we, i_wb_ack, i_wb_err;
    logic [3:0]  o_wb_stb;

    lsu_wb #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_we(i_we),
        .i_size(i_size), .i_signed(i_signed), .i_addr(i_addr), .i_data(i_data),
        .o_data(o_data), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  stb;
        logic        we;
        logic [31:0] dat;
        int unsigned wt;
        bit          err;
    } bus_t;

    typedef struct {
        bit          err;
        logic [31:0] data;
        int unsigned lat;
        int unsigned t0;
    } req_t;

    bus_t        bus_q[$];
    req_t        req_q[$];
    logic [31:0] dmem[logic [31:0]];
    logic [31:0] last_load = '0;
    int unsigned n_cmp = 0, n_bad = 0, cyc_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        if (dmem.exists(wa)) return dmem[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    // Wishbone slave: checks each access against the expected queue, then acks/errs
    initial begin
        bit          in_acc = 0;
        int unsigned cur_w = 0;
        bit          cur_e = 0;
        bus_t        p;
        logic [31:0] m;
        i_wb_ack = 0; i_wb_err = 0; i_wb_dat = '0;
        forever begin
            @(negedge clk);
            i_wb_ack = 0; i_wb_err = 0; i_wb_dat = $urandom;
            if (i_reset || !o_wb_cyc) begin
                in_acc = 0;
                if (!i_reset && ($urandom % 8 == 0)) i_wb_ack = 1;
            end else begin
                if (!in_acc) begin
                    in_acc = 1;
                    if (bus_q.size() == 0) begin
                        chk("unexpected_bus_access", o_wb_addr, 32'hxxxx_xxxx);
                        cur_w = 0; cur_e = 0;
                    end else begin
                        p = bus_q.pop_front();
                        chk("wb_addr", o_wb_addr, p.addr);
                        chk("wb_stb", {28'd0, o_wb_stb}, {28'd0, p.stb});
                        chk("wb_we", {31'd0, o_wb_we}, {31'd0, p.we});
                        if (p.we) begin
                            for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{p.stb[b]}};
                            chk("wb_dat", o_wb_dat & m, p.dat);
                        end
                        cur_w = p.wt; cur_e = p.err;
                    end
                end
                if (cur_w == 0) begin
                    if (cur_e) i_wb_err = 1; else i_wb_ack = 1;
                    i_wb_dat = rd_word(o_wb_addr);
                end else begin
                    cur_w--;
                end
            end
        end
    end

    // Completion monitor
    initial forever begin
        req_t r;
        @(negedge clk);
        if (!i_reset && o_error) chk("error_without_done", {31'd0, o_done}, 32'd1);
        if (!i_reset && o_done) begin
            if (req_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                r = req_q.pop_front();
                chk("o_error", {31'd0, o_error}, {31'd0, r.err});
                chk("o_data", o_data, r.data);
                chk("latency", cyc_n - r.t0, r.lat);
                chk("busy_at_done", {31'd0, o_busy}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int unsigned k = 0;
        while (o_busy && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (o_busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Build expected accesses and result from byte-level rules, then issue.
    // wt_mode < 0: random waits; err_mode < 0: random errors, 1: error on first access.
    task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] a, input logic [31:0] d,
                         input int wt_mode, input int err_mode);
        bus_t        acc[$];
        bus_t        cur;
        req_t        r;
        int unsigned n;
        logic [31:0] ba, wa, val, mk;
        int unsigned lane;
        bit          bad, err;
        n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        bad = (size == 2'b11) || (size != 2'b00 && a[0]);
        val = '0;
        if (!bad) begin
            for (int unsigned k = 0; k < n; k++) begin
                ba   = a + k;
                wa   = ba & 32'hFFFF_FFFC;
                lane = 3 - int'(ba & 32'd3);
                if (acc.size() == 0 || acc[acc.size()-1].addr != wa) begin
                    cur.addr = wa; cur.stb = '0; cur.we = we; cur.dat = '0;
                    cur.wt = 0; cur.err = 0;
                    acc.push_back(cur);
                end
                acc[acc.size()-1].stb[lane] = 1'b1;
                acc[acc.size()-1].dat[lane*8 +: 8] = 8'(d >> (8 * (n - 1 - k)));
                val = (val << 8) | ((rd_word(wa) >> (8 * lane)) & 32'hFF);
            end
        end
        err = bad;
        r.lat = 2;
        if (!bad) begin
            r.lat = 0;
            foreach (acc[j]) begin
                if (err) break;
                acc[j].wt  = (wt_mode < 0) ? $urandom_range(0, 3) : wt_mode;
                acc[j].err = (err_mode < 0) ? ($urandom % 8 == 0) : (err_mode == 1 && j == 0);
                err = acc[j].err;
                r.lat += acc[j].wt + ((j == 0) ? 3 : 3);
                bus_q.push_back(acc[j]);
            end
        end
        if (!we && !err) begin
            if (n < 4) begin
                mk = (32'd1 << (8 * n)) - 1;
                if (sgn && val[8*n-1]) val = val | ~mk;
            end
            last_load = val;
        end
        r.err  = err;
        r.data = last_load;
        wait_idle();
        r.t0 = cyc_n;
        req_q.push_back(r);
        i_start = 1; i_we = we; i_size = size; i_signed = sgn; i_addr = a; i_data = d;
        @(posedge clk); #1;
        i_start = 0;
        if ($urandom % 3 == 0) begin
            // Request while busy must be dropped
            i_start = 1; i_we = $urandom; i_size = $urandom; i_addr = $urandom; i_data = $urandom;
            @(posedge clk); #1;
            i_start = 0;
        end
    endtask

    initial begin
        i_reset = 1; i_start = 0; i_we = 0; i_size = 0; i_signed = 0; i_addr = '0; i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_error", {31'd0, o_error}, 32'd0);
        chk("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        chk("rst_stb", {28'd0, o_wb_stb}, 32'd0);
        chk("rst_we", {31'd0, o_wb_we}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        i_reset = 0;
        @(posedge clk); #1;

        dmem[32'h100] = 32'h1122_3344;
        issue(0, 2'b10, 0, 32'h100, 32'h0, 0, 0);
        wait_idle();
        dmem[32'h100] = 32'h0000_00F0;
        issue(0, 2'b00, 1, 32'h103, 32'h0, 0, 0);
        issue(0, 2'b00, 0, 32'h103, 32'h0, 0, 0);
        issue(1, 2'b01, 0, 32'h202, 32'h0000_BEEF, 0, 0);
        dmem[32'h2FC] = 32'h0000_AAAA;
        dmem[32'h300] = 32'hBBBB_0000;
        issue(0, 2'b10, 0, 32'h2FE, 32'h0, 0, 0);
        issue(0, 2'b01, 0, 32'h101, 32'h0, 0, 0);
        issue(0, 2'b10, 0, 32'h400, 32'h0, 0, 1);
        issue(0, 2'b11, 0, 32'h500, 32'h0, 0, 0);
        issue(0, 2'b10, 0, 32'h2FE, 32'h0, 0, 1);
        issue(1, 2'b10, 0, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, 0);
        issue(0, 2'b10, 1, 32'hFFFF_FFFE, 32'h0, 1, 0);

        // Reset in the middle of a bus cycle
        wait_idle();
        begin
            bus_t p;
            p.addr = 32'h600; p.stb = 4'b1111; p.we = 0; p.dat = '0; p.wt = 20; p.err = 0;
            bus_q.push_back(p);
        end
        i_start = 1; i_we = 0; i_size = 2'b10; i_signed = 0; i_addr = 32'h600;
        @(posedge clk); #1;
        i_start = 0;
        chk("cyc_before_reset", {31'd0, o_wb_cyc}, 32'd1);
        @(posedge clk); #1;
        i_reset = 1;
        @(posedge clk); #1;
        i_reset = 0;
        last_load = '0;
        chk("cyc_after_reset", {31'd0, o_wb_cyc}, 32'd0);
        chk("busy_after_reset", {31'd0, o_busy}, 32'd0);
        chk("data_after_reset", o_data, 32'd0);
        chk("reset_bus_q", bus_q.size(), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        issue(0, 2'b10, 0, 32'h100, 32'h0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = (i % 10 == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            issue($urandom, 2'($urandom_range(0, 3)), $urandom, a, $urandom, -1, -1);
        end

`ifdef LSU_TIMEOUT_EN
        begin
            bus_t p;
            req_t r;
            wait_idle();
            p.addr = 32'h700; p.stb = 4'b1111; p.we = 0; p.dat = '0; p.wt = 1000; p.err = 0;
            bus_q.push_back(p);
            r.err = 1; r.data = last_load; r.lat = 10; r.t0 = cyc_n;
            req_q.push_back(r);
            i_start = 1; i_we = 0; i_size = 2'b10; i_addr = 32'h700;
            @(posedge clk); #1;
            i_start = 0;
        end
`endif

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("req_q_drained", req_q.size(), 32'd0);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Load/store unit; sits directly downstream of the instruction fetcher and decode.
- Executes one LD or ST per request over the same 32-bit big-endian Wishbone-style bus, using the fetcher's port conventions: 4-bit byte-lane o_wb_stb, word-aligned o_wb_addr.
- Address (rb+imm or #imm) is already computed by the caller.
- Handles byte/halfword/word sizes, sign/zero extension, and splits word accesses at addr[1:0]=2'b10 into two halfword bus cycles.

Parameters:
- TIMEOUT_CYCLES, 255: bus watchdog limit in cycles per bus access. Used only with LSU_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  request strobe, one cycle; accepted only when o_busy=0
- i_we  in  1  1=store, 0=load
- i_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- i_signed  in  1  load sign-extends when 1, zero-extends when 0
- i_addr  in  32  byte address
- i_data  in  32  store data, right-aligned
- o_data  out  32  load result, right-aligned, extended
- o_busy  out  1  request in progress
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  one-cycle error pulse; always coincides with o_done
- o_wb_addr  out  32  {addr[31:2],2'b00}
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  4  byte-lane strobes, bit3 = bits[31:24]
- o_wb_we  out  1  write enable
- o_wb_dat  out  32  write data
- i_wb_dat  in  32  read data
- i_wb_ack  in  1  access acknowledge
- i_wb_err  in  1  access error

Behaviour:
- Reset values: o_busy=0, o_done=0, o_error=0, o_wb_cyc=0, o_wb_stb=0, o_wb_we=0, o_data=0, state=IDLE. Reset mid-access drops o_wb_cyc at the next edge; no o_done is produced.
- States: IDLE, ACC1, ACC2, DONE.
- IDLE: on i_start, latch all request inputs, set o_busy=1.
  - Misaligned or illegal request (half at odd address, word at addr[0]=1, size 11): go to DONE with error. No bus cycle is issued.
  - Otherwise go to ACC1.
- Lane map (big-endian): byte at offset 0..3 → stb 1000/0100/0010/0001, data on lanes [31:24]..[7:0].
  - Half at offset 0 → 1100; offset 2 → 0011.
  - Word at offset 0 → 1111.
  - Store data is replicated onto the selected lanes.
- ACC1: o_wb_cyc=1 with stb/we/dat driven, held until i_wb_ack or i_wb_err is sampled high while cyc=1. Cyc deasserts on the following edge. Ack or err with cyc=0 is ignored.
  - Split word at offset 2: ACC1 uses stb 0011 at word A and transfers data bits[31:16]. On ack go to ACC2.
- ACC2: o_wb_addr = A+4, stb 1100, transfers data bits[15:0]. At least one idle cycle with cyc=0 separates ACC1 and ACC2.
- DONE: o_done=1 for exactly one cycle.
  - o_data updated in the same cycle and held until the next completed load. Stores and errors leave o_data unchanged.
  - o_error=1 if i_wb_err was seen or the request was misaligned.
  - o_busy returns to 0 in this cycle.
- Error during ACC1 of a split access: ACC2 is skipped.
- i_start while o_busy=1 is ignored; it is not queued.
- Latency with zero-wait ack (ack in first cyc cycle):
  - aligned access: start at T, cyc at T+1, o_done at T+3;
  - split access: o_done at T+6;
  - misaligned: o_done at T+2.
- Address wrap: A+4 wraps modulo 2^32.

Optional Feature:
- LSU_TIMEOUT_EN defined: a per-access counter counts cycles with cyc=1. If it reaches TIMEOUT_CYCLES without ack or err, cyc drops and the request finishes via DONE with o_error=1. The counter is cleared at the start of each access.
- Not defined: no counter; the bus cycle waits indefinitely for ack or err.

Test Plan:
- Load word, addr 0x100, slave returns 0x11223344 → stb 1111, o_data 0x11223344, o_done at T+3.
- Signed byte load, addr 0x103, i_wb_dat 0x000000F0 → stb 0001, o_data 0xFFFFFFF0. Same with i_signed=0 → 0x000000F0.
- Store half 0xBEEF at addr 0x202 → wb_addr 0x200, stb 0011, wb_dat[15:0]=0xBEEF, we=1, o_done with o_error=0.
- Split word load at addr 0x2FE, words 0x2FC=0x0000AAAA and 0x300=0xBBBB0000 → two bus cycles (0x2FC stb 0011, then 0x300 stb 1100), o_data 0xAAAABBBB, o_done at T+6.
- Half load at addr 0x101 → no cyc, o_done with o_error at T+2. Then i_wb_err on a word load → o_error=1, o_data unchanged.
- i_reset asserted while cyc=1 → cyc=0 next cycle, no o_done. A new request afterwards completes normally. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8 and a never-acking slave → o_error after 8 cyc cycles.
